comp_ctrl_sequencer: RTL



---
 rtl/comp_ctrl_pkg.sv | 31 +++
 rtl/comp_ch_fsm.sv | 129 ++++++++++++
 rtl/comp_ctrl_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/comp_ctrl_pkg.sv
// Shared definitions for the component-control sequencer.
// Holds the per-channel state encoding, the Avalon register offsets, the
// default cycle constants and the width of the transition counter.
package comp_ctrl_pkg;

    // Channel lifecycle states
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_POWERUP  = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_ON       = 3'd3,
        ST_STOPPING = 3'd4,
        ST_FAULT    = 3'd5
    } ch_state_t;

    // Avalon word offsets
    localparam logic [1:0] REG_STATE     = 2'd0;
    localparam logic [1:0] REG_FAULT     = 2'd1;
    localparam logic [1:0] REG_IRQ_MASK  = 2'd2;
    localparam logic [1:0] REG_TRANS_CNT = 2'd3;

    // Default sequencing constants
    localparam int DEF_N_CH          = 3;
    localparam int DEF_START_CYCLES  = 16;
    localparam int DEF_READY_TIMEOUT = 200;
    localparam int DEF_STOP_CYCLES   = 8;
    localparam int DEF_CNT_W         = 8;

    localparam int TRANS_CNT_W = 16;

endpackage

// File: rtl/comp_ch_fsm.sv
// One managed component channel: turns a level request into a timed
// power-up / reset-release / ready-wait / shutdown sequence.
//
// Ports:
//   clk, srst    clock and synchronous active-high reset
//   req          requested on/off level
//   ready        component reports operational
//   en, rst      registered component enable and component reset
//   on, busy     status for the register file (ON; POWERUP|WAIT_RDY|STOPPING)
//   on_pulse     one-cycle pulse during the first ON cycle
//   fault_pulse  one-cycle pulse during the first FAULT cycle
module comp_ch_fsm
    import comp_ctrl_pkg::*;
#(
    parameter int START_CYCLES  = DEF_START_CYCLES,
    parameter int READY_TIMEOUT = DEF_READY_TIMEOUT,
    parameter int STOP_CYCLES   = DEF_STOP_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic srst,
    input  logic req,
    input  logic ready,
    output logic en,
    output logic rst,
    output logic on,
    output logic busy,
    output logic on_pulse,
    output logic fault_pulse
);

    // Counters load N-1 so that a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] READY_LOAD = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_CYCLES - 1);

    ch_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // en/rst are assigned together with each state change so the pins come
    // straight from flops.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= ST_OFF;
            cnt_reg     <= '0;
            en          <= 1'b0;
            rst         <= 1'b1;
            on_pulse    <= 1'b0;
            fault_pulse <= 1'b0;
        end else begin
            on_pulse    <= 1'b0;
            fault_pulse <= 1'b0;
            case (state_reg)
                ST_OFF: begin
                    if (req) begin
                        state_reg <= ST_POWERUP;
                        cnt_reg   <= START_LOAD;
                        en        <= 1'b1;
                        rst       <= 1'b1;
                    end
                end
                ST_POWERUP: begin
                    // A dropped request aborts the bring-up immediately.
                    if (!req) begin
                        state_reg <= ST_STOPPING;
                        cnt_reg   <= STOP_LOAD;
                    end else if (cnt_reg == '0) begin
                        state_reg <= ST_WAIT_RDY;
                        cnt_reg   <= READY_LOAD;
                        rst       <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    // Priority: request drop, then ready, then timeout.
                    if (!req) begin
                        state_reg <= ST_STOPPING;
                        cnt_reg   <= STOP_LOAD;
                        rst       <= 1'b1;
                    end else if (ready) begin
                        state_reg <= ST_ON;
                        on_pulse  <= 1'b1;
                    end else if (cnt_reg == '0) begin
                        state_reg   <= ST_FAULT;
                        en          <= 1'b0;
                        rst         <= 1'b1;
                        fault_pulse <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_ON: begin
                    // Loss of ready while ON is deliberately not acted upon.
                    if (!req) begin
                        state_reg <= ST_STOPPING;
                        cnt_reg   <= STOP_LOAD;
                        rst       <= 1'b1;
                    end
                end
                ST_STOPPING: begin
                    // Runs to completion even if the request comes back.
                    if (cnt_reg == '0) begin
                        state_reg <= ST_OFF;
                        en        <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Software must drop the request to re-arm the channel.
                    if (!req) begin
                        state_reg <= ST_OFF;
                    end
                end
                default: begin
                    state_reg <= ST_OFF;
                    en        <= 1'b0;
                    rst       <= 1'b1;
                end
            endcase
        end
    end

    assign on   = (state_reg == ST_ON);
    assign busy = (state_reg == ST_POWERUP) || (state_reg == ST_WAIT_RDY) ||
                  (state_reg == ST_STOPPING);

endmodule

// File: rtl/comp_ctrl_sequencer.sv
// Component-control sequencer: one timed power sequence per bit of the
// component-control PIO word, with status, sticky faults, an interrupt
// mask and an ON-transition counter visible over a small Avalon-MM slave.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   ctrl_in[N_CH]         requested on/off level per channel (PIO out_port)
//   comp_ready[N_CH]      component reports operational
//   comp_en[N_CH]         component enable
//   comp_rst[N_CH]        component reset, active-high
//   address, chipselect, write_n, writedata, readdata   Avalon-MM slave
//   irq                   high while any unmasked sticky fault is set
//
// Registers: 0 STATE {busy,on} pairs (RO), 1 FAULT (W1C), 2 IRQ_MASK (RW),
// 3 TRANS_CNT (RO, any write clears).
//
// Build option: define CTRL_SYNC_EN to put ctrl_in and comp_ready through
// 2-flop synchronizers (adds 2 cycles to every input-to-action latency).
module comp_ctrl_sequencer
    import comp_ctrl_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int START_CYCLES  = DEF_START_CYCLES,
    parameter int READY_TIMEOUT = DEF_READY_TIMEOUT,
    parameter int STOP_CYCLES   = DEF_STOP_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] ctrl_in,
    input  logic [N_CH-1:0] comp_ready,
    output logic [N_CH-1:0] comp_en,
    output logic [N_CH-1:0] comp_rst,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            irq
);

    logic [N_CH-1:0] ctrl_eff;
    logic [N_CH-1:0] ready_eff;

`ifdef CTRL_SYNC_EN
    logic [N_CH-1:0] ctrl_s1_reg, ctrl_s2_reg;
    logic [N_CH-1:0] ready_s1_reg, ready_s2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_s1_reg  <= '0;
            ctrl_s2_reg  <= '0;
            ready_s1_reg <= '0;
            ready_s2_reg <= '0;
        end else begin
            ctrl_s1_reg  <= ctrl_in;
            ctrl_s2_reg  <= ctrl_s1_reg;
            ready_s1_reg <= comp_ready;
            ready_s2_reg <= ready_s1_reg;
        end
    end

    assign ctrl_eff  = ctrl_s2_reg;
    assign ready_eff = ready_s2_reg;
`else
    assign ctrl_eff  = ctrl_in;
    assign ready_eff = comp_ready;
`endif

    logic [N_CH-1:0]   ch_on;
    logic [N_CH-1:0]   ch_busy;
    logic [N_CH-1:0]   on_pulse;
    logic [N_CH-1:0]   fault_pulse;
    logic [2*N_CH-1:0] state_bits;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            comp_ch_fsm #(
                .START_CYCLES  (START_CYCLES),
                .READY_TIMEOUT (READY_TIMEOUT),
                .STOP_CYCLES   (STOP_CYCLES),
                .CNT_W         (CNT_W)
            ) u_ch (
                .clk         (clk),
                .srst        (reset),
                .req         (ctrl_eff[gi]),
                .ready       (ready_eff[gi]),
                .en          (comp_en[gi]),
                .rst         (comp_rst[gi]),
                .on          (ch_on[gi]),
                .busy        (ch_busy[gi]),
                .on_pulse    (on_pulse[gi]),
                .fault_pulse (fault_pulse[gi])
            );
            assign state_bits[2*gi+1:2*gi] = {ch_busy[gi], ch_on[gi]};
        end
    endgenerate

    // Several channels may reach ON in the same cycle; add them all.
    logic [TRANS_CNT_W-1:0] on_sum;
    always_comb begin
        on_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            on_sum = on_sum + {{(TRANS_CNT_W-1){1'b0}}, on_pulse[i]};
        end
    end

    logic                   wr_en;
    logic [N_CH-1:0]        fault_clr;
    logic [N_CH-1:0]        fault_reg;
    logic [N_CH-1:0]        irq_mask_reg;
    logic [TRANS_CNT_W-1:0] trans_cnt_reg;
    logic                   irq_reg;

    assign wr_en     = chipselect && !write_n;
    assign fault_clr = (wr_en && address == REG_FAULT) ? writedata[N_CH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_reg     <= '0;
            irq_mask_reg  <= '0;
            trans_cnt_reg <= '0;
            irq_reg       <= 1'b0;
        end else begin
            // A new fault in the clearing cycle survives the clear.
            fault_reg <= (fault_reg & ~fault_clr) | fault_pulse;
            if (wr_en && address == REG_IRQ_MASK) begin
                irq_mask_reg <= writedata[N_CH-1:0];
            end
            // Wraps naturally at 0xFFFF.
            trans_cnt_reg <= ((wr_en && address == REG_TRANS_CNT) ? '0 : trans_cnt_reg) + on_sum;
            irq_reg       <= |(fault_reg & irq_mask_reg);
        end
    end

    assign irq = irq_reg;

    always_comb begin
        readdata = '0;
        case (address)
            REG_STATE:     readdata = 32'(state_bits);
            REG_FAULT:     readdata = 32'(fault_reg);
            REG_IRQ_MASK:  readdata = 32'(irq_mask_reg);
            REG_TRANS_CNT: readdata = 32'(trans_cnt_reg);
            default:       readdata = '0;
        endcase
    end

    // Upper write-data bits have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:N_CH];

endmodule
